// File: rtl/complex_subtractor_pipe.sv
// Two-stage pipelined complex subtractor Y = A - B with valid/ready handshake and sticky overflow.
// Build option: define SUBTRACTOR_SATURATE_EN to clamp overflowed components instead of wrapping.
module complex_subtractor_pipe #(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2*W-1:0] A,
    input  logic [2*W-1:0] B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] Y,
    output logic           OVF,
    input  logic           OVF_CLR
);

    logic signed [W:0] d_re_p1;
    logic signed [W:0] d_im_p1;
    logic              vld_p1;
    logic              en1;
    logic              en2;
    logic signed [W:0] d_re;
    logic signed [W:0] d_im;
    logic              ovf_p1;

    function automatic logic is_ovf(input logic signed [W:0] d);
        return d[W] != d[W-1];
    endfunction

    function automatic logic [W-1:0] reduce(input logic signed [W:0] d);
`ifdef SUBTRACTOR_SATURATE_EN
        if (is_ovf(d)) begin
            return d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        return d[W-1:0];
    endfunction

    // The extra sign bit keeps A - (most negative B) exact until stage 2.
    assign d_re = $signed({A[2*W-1], A[2*W-1:W]}) - $signed({B[2*W-1], B[2*W-1:W]});
    assign d_im = $signed({A[W-1], A[W-1:0]}) - $signed({B[W-1], B[W-1:0]});

    assign en2      = !OUT_VALID || OUT_READY;
    assign en1      = !vld_p1 || en2;
    assign IN_READY = en1;
    assign ovf_p1   = is_ovf(d_re_p1) || is_ovf(d_im_p1);

    // Stage 1: full-precision differences
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
        end else if (en1) begin
            vld_p1 <= IN_VALID;
        end
        if (en1) begin
            d_re_p1 <= d_re;
            d_im_p1 <= d_im;
        end
    end

    // Stage 2: reduce to W bits, register result and sticky overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            Y         <= '0;
            OVF       <= 1'b0;
        end else begin
            if (en2) begin
                OUT_VALID <= vld_p1;
                if (vld_p1) begin
                    Y <= {reduce(d_re_p1), reduce(d_im_p1)};
                end
            end
            if (en2 && vld_p1 && ovf_p1) begin
                OVF <= 1'b1;
            end else if (OVF_CLR) begin
                OVF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_complex_subtractor_pipe.sv
// Randomized and directed bench for complex_subtractor_pipe against an arithmetic scoreboard model.
module tb_complex_subtractor_pipe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] Y;
    logic        OVF;
    logic        OVF_CLR = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit sticky = 1'b0;

    typedef struct {
        logic [31:0] y;
        bit          ovf;
        int          acc;
    } ent_t;
    ent_t q[$];

    complex_subtractor_pipe #(.W(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Y(Y), .OVF(OVF), .OVF_CLR(OVF_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    // Plain integer arithmetic on each component, then wrap or clamp to 16 bits.
    function automatic logic [15:0] comp(input int d);
        logic [15:0] r;
        r = 16'(d);
`ifdef SUBTRACTOR_SATURATE_EN
        if (d > 32767) r = 16'h7FFF;
        else if (d < -32768) r = 16'h8000;
`endif
        return r;
    endfunction

    function automatic ent_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        ent_t e;
        int dr, di;
        dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
        di = int'($signed(a[15:0])) - int'($signed(b[15:0]));
        e.y   = {comp(dr), comp(di)};
        e.ovf = (dr > 32767) || (dr < -32768) || (di > 32767) || (di < -32768);
        e.acc = acc;
        return e;
    endfunction

    task automatic step(input bit rst, input bit iv, input logic [31:0] a, input logic [31:0] b,
                        input bit ordy, input bit clr, output bit accepted);
        bit exp_ov, exp_ir;
        @(negedge CLK);
        RST = rst; IN_VALID = iv; A = a; B = b; OUT_READY = ordy; OVF_CLR = clr;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
        exp_ir = !(q.size() == 2 && !ordy);
        chk("out_valid", 32'(OUT_VALID), 32'(exp_ov));
        chk("in_ready", 32'(IN_READY), 32'(exp_ir));
        chk("ovf", 32'(OVF), 32'(sticky || (exp_ov && q[0].ovf)));
        if (exp_ov) chk("y", Y, q[0].y);
        accepted = 1'b0;
        if (rst) begin
            q.delete();
            sticky = 1'b0;
        end else begin
            if (exp_ov && ordy) begin
                sticky = sticky || q[0].ovf;
                void'(q.pop_front());
            end
            if (clr) sticky = 1'b0;
            if (iv && exp_ir) begin
                q.push_back(model(a, b, cyc));
                accepted = 1'b1;
            end
        end
        @(posedge CLK);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit acc;
        int sent;
        logic [31:0] ra, rb;

        // reset held for two cycles
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        #1;
        chk("rst_y", Y, 32'h0);
        chk("rst_ovf", 32'(OVF), 32'h0);
        idle(1);

        // basic: {-10,-1} - {-30,-1}
        step(1'b0, 1'b1, {16'hFFF6, 16'hFFFF}, {16'hFFE2, 16'hFFFF}, 1'b1, 1'b0, acc);
        idle(1);
        #1;
        chk("basic_y", Y, 32'h0014_0000);
        idle(2);

        // overflow in both components, then clear on an empty pipeline
        step(1'b0, 1'b1, 32'h7FFF_8000, 32'hFFFF_0001, 1'b1, 1'b0, acc);
        idle(1);
        #1;
`ifdef SUBTRACTOR_SATURATE_EN
        chk("ovf_y", Y, 32'h7FFF_8000);
`else
        chk("ovf_y", Y, 32'h8000_7FFF);
`endif
        idle(2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
        idle(1);

        // clear asserted in the very cycle an overflowing word loads stage 2
        step(1'b0, 1'b1, 32'h8000_0000, 32'h0001_0000, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
        idle(3);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);

        // backpressure: 8 back-to-back words with downstream stalled
        sent = 0;
        for (int i = 0; i < 16; i++) begin
            ra = {pick(), pick()};
            rb = {pick(), pick()};
            step(1'b0, sent < 8, ra, rb, !(i >= 3 && i <= 7), 1'b0, acc);
            if (acc) sent++;
        end
        idle(3);
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // reset with two words in flight and downstream stalled
        step(1'b0, 1'b1, 32'h7FFF_0000, 32'h8000_0000, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 32'h1234_5678, 32'h0034_0078, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        #1;
        chk("mid_rst_valid", 32'(OUT_VALID), 32'h0);
        chk("mid_rst_ovf", 32'(OVF), 32'h0);
        step(1'b0, 1'b1, 32'h0005_0003, 32'h0002_0007, 1'b1, 1'b0, acc);
        idle(3);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            ra = {pick(), pick()};
            rb = {pick(), pick()};
            step(1'b0, $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 9) < 7, 1'b0, acc);
        end
        idle(6);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
